// File: rtl/keygen_seq_ctrl.sv
// Sequences one RSA key-generation run: RNG, private-key restart, d wait, then e*d mod tot == 1 check.
// Latency: RNG wait + RST_CYC + d wait + W+1 check cycles; up to MAX_RETRY extra attempts.
// Backpressure: none; start is honoured only in IDLE/DONE/FAIL, stray rng_flag/pkg_complete are ignored.
module keygen_seq_ctrl #(
    parameter int W         = 24,
    parameter int TIMEOUT   = 4096,
    parameter int MAX_RETRY = 3,
    parameter int RST_CYC   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         rng_en,
    input  logic         rng_flag,
    input  logic [W-1:0] rng_e,
    input  logic [W-1:0] rng_n,
    input  logic [W-1:0] rng_tot,
    output logic         pkg_rst,
    input  logic         pkg_complete,
    input  logic [W-1:0] pkg_d,
    output logic         busy,
    output logic         key_valid,
    output logic         error,
    output logic [W-1:0] n_out,
    output logic [W-1:0] e_out,
    output logic [W-1:0] d_out,
    output logic [1:0]   retry_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = $clog2(W);
    localparam logic [1:0] MAXR = 2'(MAX_RETRY);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GEN   = 3'd1;
    localparam logic [2:0] S_KRST  = 3'd2;
    localparam logic [2:0] S_KWAIT = 3'd3;
    localparam logic [2:0] S_CHK   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_FAIL  = 3'd6;

    logic [2:0]    state;
    logic [W-1:0]  e_r, n_r, tot_r, d_r, acc;
    logic [IW-1:0] idx;
    // Counts GEN/KWAIT cycles, KRST pulse length, and in CHK marks pre-check (0) vs multiply (1).
    logic [TW-1:0] timer;

    logic [W:0]    dbl, sum;
    logic [W-1:0]  acc_dbl, acc_nxt;
    logic          timer_exp, pre_bad, fail_now, pass_now;

    assign rng_en  = (state == S_GEN);
    assign pkg_rst = (state == S_KRST);
    assign busy    = (state == S_GEN) || (state == S_KRST) || (state == S_KWAIT) || (state == S_CHK);

    assign timer_exp = (timer == TW'(TIMEOUT - 1));
    assign pre_bad   = (tot_r <= W'(1)) || (e_r == '0) || (e_r >= tot_r);

    // One MSB-first multiply step: double then conditionally add e, each reduced by one subtract.
    always_comb begin
        dbl     = {acc, 1'b0};
        acc_dbl = (dbl >= {1'b0, tot_r}) ? W'(dbl - {1'b0, tot_r}) : dbl[W-1:0];
        sum     = {1'b0, acc_dbl} + (d_r[idx] ? {1'b0, e_r} : '0);
        acc_nxt = (sum >= {1'b0, tot_r}) ? W'(sum - {1'b0, tot_r}) : sum[W-1:0];
    end

    // Attempt outcome for this cycle: timeout, degenerate operands, or final product check.
    always_comb begin
        fail_now = 1'b0;
        pass_now = 1'b0;
        case (state)
            S_GEN:   fail_now = !rng_flag && timer_exp;
            S_KWAIT: fail_now = !pkg_complete && timer_exp;
            S_CHK: begin
                if (timer == '0) begin
                    fail_now = pre_bad;
                end else if (idx == '0) begin
                    pass_now = (acc_nxt == W'(1));
                    fail_now = (acc_nxt != W'(1));
                end
            end
            default: ;
        endcase
    end

    // Sequencer state, operand capture, modular-multiply datapath and published key.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            e_r       <= '0;
            n_r       <= '0;
            tot_r     <= '0;
            d_r       <= '0;
            acc       <= '0;
            idx       <= '0;
            timer     <= '0;
            key_valid <= 1'b0;
            error     <= 1'b0;
            n_out     <= '0;
            e_out     <= '0;
            d_out     <= '0;
            retry_cnt <= '0;
        end else if (fail_now) begin
            timer <= '0;
            if (retry_cnt < MAXR) begin
                retry_cnt <= retry_cnt + 2'd1;
                state     <= S_GEN;
            end else begin
                state <= S_FAIL;
                error <= 1'b1;
            end
        end else if (pass_now) begin
            state     <= S_DONE;
            key_valid <= 1'b1;
            n_out     <= n_r;
            e_out     <= e_r;
            d_out     <= d_r;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        state     <= S_GEN;
                        timer     <= '0;
                        retry_cnt <= '0;
                        key_valid <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                S_GEN: begin
                    if (rng_flag) begin
                        e_r   <= rng_e;
                        n_r   <= rng_n;
                        tot_r <= rng_tot;
                        timer <= '0;
                        state <= S_KRST;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_KRST: begin
                    if (timer == TW'(RST_CYC - 1)) begin
                        timer <= '0;
                        state <= S_KWAIT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_KWAIT: begin
                    if (pkg_complete) begin
                        d_r   <= pkg_d;
                        timer <= '0;
                        state <= S_CHK;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_CHK: begin
                    if (timer == '0) begin
                        acc   <= '0;
                        idx   <= IW'(W - 1);
                        timer <= TW'(1);
                    end else begin
                        acc <= acc_nxt;
                        idx <= idx - IW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
